// File: rtl/ulpi_reg_arbiter.sv
// ULPI register access engine (write, read, STOP-only) shared by two requesters.
// Port 0 has fixed priority. The engine yields the bus to PHY dir and to the TX packet path.
module ulpi_reg_arbiter #(
   parameter int NXT_TIMEOUT = 255
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       ulpi_dir,
   input  logic       ulpi_nxt,
   input  logic [7:0] ulpi_data_i,
   output logic [7:0] ulpi_data_o,
   output logic       ulpi_data_oe,
   output logic       ulpi_stp_o,
   input  logic       tx_busy_i,
   input  logic       p0_req_i,
   input  logic       p0_read_i,
   input  logic       p0_stop_i,
   input  logic [7:0] p0_addr_i,
   input  logic [7:0] p0_data_i,
   output logic       p0_busy_o,
   output logic       p0_done_o,
   output logic       p0_err_o,
   input  logic       p1_req_i,
   input  logic       p1_read_i,
   input  logic [7:0] p1_addr_i,
   input  logic [7:0] p1_data_i,
   output logic       p1_busy_o,
   output logic       p1_done_o,
   output logic       p1_err_o,
   output logic [7:0] p1_rdata_o
);

   typedef enum logic [3:0] {
      S_IDLE, S_CMD, S_WDATA, S_STP, S_RTURN, S_RDATA, S_RWAIT, S_ABORT, S_GAP, S_DONE
   } state_t;

   localparam logic [7:0] TMO_LAST = 8'(NXT_TIMEOUT - 1);

   function automatic logic [7:0] txcmd(input logic rd, input logic [5:0] a);
      return {1'b1, rd, a};
   endfunction

   state_t     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic       owner_q, owner_d;
   logic       read_q, read_d;
   logic [5:0] addr_q, addr_d;
   logic [7:0] wdata_q, wdata_d;
   logic       err_q, err_d;
   logic [7:0] rdata_q, rdata_d;
   logic [7:0] data_q, data_d;
   logic       oe_q, oe_d, stp_q, stp_d;
   logic       busy0_q, busy0_d, busy1_q, busy1_d;
   logic       done0_q, done0_d, done1_q, done1_d;
   logic       err0_q, err0_d, err1_q, err1_d;
   logic       timed_out;
   logic       addr_hi_unused;

   // Address bits [7:6] carry no meaning for ULPI register access.
   assign addr_hi_unused = ^{p0_addr_i[7:6], p1_addr_i[7:6]};

   // State and output registers with synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= 8'h00;
         owner_q <= 1'b0;
         read_q  <= 1'b0;
         addr_q  <= 6'h00;
         wdata_q <= 8'h00;
         err_q   <= 1'b0;
         rdata_q <= 8'h00;
         data_q  <= 8'h00;
         oe_q    <= 1'b0;
         stp_q   <= 1'b0;
         busy0_q <= 1'b0;
         busy1_q <= 1'b0;
         done0_q <= 1'b0;
         done1_q <= 1'b0;
         err0_q  <= 1'b0;
         err1_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         owner_q <= owner_d;
         read_q  <= read_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
         data_q  <= data_d;
         oe_q    <= oe_d;
         stp_q   <= stp_d;
         busy0_q <= busy0_d;
         busy1_q <= busy1_d;
         done0_q <= done0_d;
         done1_q <= done1_d;
         err0_q  <= err0_d;
         err1_q  <= err1_d;
      end
   end

   // Next-state, request latching and next output values.
   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      read_d    = read_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      err_d     = err_q;
      rdata_d   = rdata_q;
      timed_out = (cnt_q == TMO_LAST);

      case (state_q)
         S_IDLE: begin
            if (!ulpi_dir && !tx_busy_i && p0_req_i) begin
               owner_d = 1'b0;
               read_d  = p0_read_i & ~p0_stop_i;
               addr_d  = p0_addr_i[5:0];
               wdata_d = p0_data_i;
               err_d   = 1'b0;
               state_d = p0_stop_i ? S_STP : S_CMD;
            end else if (!ulpi_dir && !tx_busy_i && p1_req_i) begin
               owner_d = 1'b1;
               read_d  = p1_read_i;
               addr_d  = p1_addr_i[5:0];
               wdata_d = p1_data_i;
               err_d   = 1'b0;
               state_d = S_CMD;
            end else begin
               state_d = S_IDLE;
            end
         end
         // dir wins over nxt: with dir high the PHY is reporting RX, not accepting our byte.
         S_CMD: begin
            if (ulpi_dir) begin
               state_d = S_ABORT;
            end else if (ulpi_nxt) begin
               state_d = read_q ? S_RTURN : S_WDATA;
            end else if (timed_out) begin
               state_d = S_DONE;
               err_d   = 1'b1;
            end else begin
               state_d = S_CMD;
            end
         end
         S_WDATA: begin
            if (ulpi_dir) begin
               state_d = S_ABORT;
            end else if (ulpi_nxt) begin
               state_d = S_STP;
            end else if (timed_out) begin
               state_d = S_DONE;
               err_d   = 1'b1;
            end else begin
               state_d = S_WDATA;
            end
         end
         S_STP: state_d = S_DONE;
         S_RTURN: begin
            if (ulpi_dir) begin
               state_d = S_RDATA;
            end else if (timed_out) begin
               state_d = S_DONE;
               err_d   = 1'b1;
            end else begin
               state_d = S_RTURN;
            end
         end
         S_RDATA: begin
            if (owner_q) begin
               rdata_d = ulpi_data_i;
            end else begin
               rdata_d = rdata_q;
            end
            state_d = S_RWAIT;
         end
         S_RWAIT: state_d = ulpi_dir ? S_RWAIT : S_DONE;
         S_ABORT: state_d = ulpi_dir ? S_ABORT : S_GAP;
         S_GAP:   state_d = S_CMD;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      cnt_d = (state_d == state_q) ? cnt_q + 8'd1 : 8'd0;

      data_d = 8'h00;
      oe_d   = 1'b0;
      stp_d  = 1'b0;
      case (state_d)
         S_CMD: begin
            data_d = txcmd(read_d, addr_d);
            oe_d   = 1'b1;
         end
         S_WDATA: begin
            data_d = wdata_d;
            oe_d   = 1'b1;
         end
         S_STP: begin
            oe_d  = 1'b1;
            stp_d = 1'b1;
         end
         default: begin
            data_d = 8'h00;
            oe_d   = 1'b0;
         end
      endcase

      busy0_d = (state_d != S_IDLE) && !owner_d;
      busy1_d = (state_d != S_IDLE) && owner_d;
      done0_d = (state_d == S_DONE) && !owner_d;
      done1_d = (state_d == S_DONE) && owner_d;
      err0_d  = done0_d && err_d;
      err1_d  = done1_d && err_d;
   end

   assign ulpi_data_o  = data_q;
   assign ulpi_data_oe = oe_q;
   assign ulpi_stp_o   = stp_q;
   assign p0_busy_o    = busy0_q;
   assign p1_busy_o    = busy1_q;
   assign p0_done_o    = done0_q;
   assign p1_done_o    = done1_q;
   assign p0_err_o     = err0_q;
   assign p1_err_o     = err1_q;
   assign p1_rdata_o   = rdata_q;

endmodule
